// File: rtl/nv_nvdla_slcg_pkg.sv
// Shared definitions for the second-level clock gater.
package nv_nvdla_slcg_pkg;

    // Per-channel gating FSM encoding.
    typedef enum logic [1:0] {
        SLCG_RUN   = 2'd0,
        SLCG_DRAIN = 2'd1,
        SLCG_GATED = 2'd2
    } slcg_state_e;

endpackage

// File: rtl/nv_nvdla_slcg_multi_if.sv
// Control/status bundle between the partition top and the clock gater.
interface nv_nvdla_slcg_multi_if #(
    parameter int NUM_CH  = 4,
    parameter int NUM_SRC = 2,
    parameter int HOLD_W  = 8
);
    logic                        dla_clk_ovr_on_sync;
    logic                        global_clk_ovr_on_sync;
    logic                        tmc2slcg_disable_clock_gating;
    logic [NUM_CH*NUM_SRC-1:0]   slcg_en_src;
    logic [HOLD_W-1:0]           cfg_hold_cycles;
    logic [NUM_CH-1:0]           nvdla_core_gated_clk;
    logic [NUM_CH-1:0]           slcg_clk_en;
    logic [NUM_CH-1:0]           slcg_ch_gated;

    modport master (
        output dla_clk_ovr_on_sync, global_clk_ovr_on_sync,
               tmc2slcg_disable_clock_gating, slcg_en_src, cfg_hold_cycles,
        input  nvdla_core_gated_clk, slcg_clk_en, slcg_ch_gated
    );

    modport slave (
        input  dla_clk_ovr_on_sync, global_clk_ovr_on_sync,
               tmc2slcg_disable_clock_gating, slcg_en_src, cfg_hold_cycles,
        output nvdla_core_gated_clk, slcg_clk_en, slcg_ch_gated
    );
endinterface

// File: rtl/nv_nvdla_slcg_chan.sv
// One gated-clock channel: idle hold-off FSM, down-counter and clock gate.
//
// state      | meaning
// -----------+--------------------------------------------------------
// SLCG_RUN   | clock requested, enable high
// SLCG_DRAIN | request dropped, counting down the hold-off, enable high
// SLCG_GATED | hold-off expired with request still low, enable low
module nv_nvdla_slcg_chan
    import nv_nvdla_slcg_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int HOLD_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               ovr,
    input  logic [HOLD_W-1:0]  cfg_hold_cycles,
    output logic               gated_clk,
    output logic               clk_en,
    output logic               ch_gated
);
    slcg_state_e       state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              req;
    logic              en_lat;

    assign req = &src;

    // State and hold-off counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLCG_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the hold-off is captured only when leaving RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SLCG_RUN: begin
                if (!req) begin
                    if (cfg_hold_cycles == '0) begin
                        state_d = SLCG_GATED;
                    end else begin
                        state_d = SLCG_DRAIN;
                        cnt_d   = cfg_hold_cycles - HOLD_W'(1);
                    end
                end
            end
            SLCG_DRAIN: begin
                if (req) begin
                    state_d = SLCG_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = SLCG_GATED;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            SLCG_GATED: begin
                if (req) state_d = SLCG_RUN;
            end
            default: begin
                state_d = SLCG_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign ch_gated = (state_q == SLCG_GATED);
    assign clk_en   = !ch_gated | ovr;

    // Clock-gate enable latch: transparent while the clock is low so the
    // gated output can only change on a clean low phase.
    always_latch begin
        if (!clk) en_lat = clk_en;
    end

    assign gated_clk = clk & en_lat;

endmodule

// File: rtl/nv_nvdla_slcg_multi.sv
// Second-level clock gater: NUM_CH independently gated copies of the core
// clock, with a shared override that forces every copy on.
module nv_nvdla_slcg_multi #(
    parameter int NUM_CH  = 4,
    parameter int NUM_SRC = 2,
    parameter int HOLD_W  = 8
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    nv_nvdla_slcg_multi_if.slave  bus
);
    logic              ovr;
    logic [NUM_CH-1:0] gated_clk;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] ch_gated;

    // The override does not touch channel state; it only ORs into the enable.
    assign ovr = bus.dla_clk_ovr_on_sync
               | bus.global_clk_ovr_on_sync
               | bus.tmc2slcg_disable_clock_gating;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        nv_nvdla_slcg_chan #(
            .NUM_SRC (NUM_SRC),
            .HOLD_W  (HOLD_W)
        ) u_chan (
            .clk             (nvdla_core_clk),
            .rst             (nvdla_core_rst),
            .src             (bus.slcg_en_src[c*NUM_SRC +: NUM_SRC]),
            .ovr             (ovr),
            .cfg_hold_cycles (bus.cfg_hold_cycles),
            .gated_clk       (gated_clk[c]),
            .clk_en          (clk_en[c]),
            .ch_gated        (ch_gated[c])
        );
    end

    assign bus.nvdla_core_gated_clk = gated_clk;
    assign bus.slcg_clk_en          = clk_en;
    assign bus.slcg_ch_gated        = ch_gated;

endmodule

// File: tb/tb_nv_nvdla_slcg_multi.sv
// Bench for the multi-channel clock gater: per-edge vector table with a
// scoreboard queue, plus hand sequences for clock-level behaviour.
module tb_nv_nvdla_slcg_multi;

    typedef struct {
        logic       rst;
        logic [7:0] src;
        logic [7:0] cfg;
        logic [2:0] ovr;     // {tmc, global, dla}
        logic [3:0] exp_en;
        logic [3:0] exp_g;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] en;
        logic [3:0] g;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    vec_t vecs[$];
    exp_t sb[$];
    int   rise[4];
    logic [3:0] prev_g = 4'h0;

    nv_nvdla_slcg_multi_if #(.NUM_CH(4), .NUM_SRC(2), .HOLD_W(8)) bus();

    nv_nvdla_slcg_multi #(.NUM_CH(4), .NUM_SRC(2), .HOLD_W(8)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 4; i++) rise[i] = 0;

    always @(bus.nvdla_core_gated_clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.nvdla_core_gated_clk[i] && !prev_g[i]) rise[i] = rise[i] + 1;
        prev_g = bus.nvdla_core_gated_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] s, input logic [7:0] c,
                       input logic [2:0] o, input logic [3:0] e, input logic [3:0] g,
                       input string n);
        vec_t v;
        v.rst = r; v.src = s; v.cfg = c; v.ovr = o; v.exp_en = e; v.exp_g = g; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [7:0] s, input logic [7:0] c, input logic [2:0] o);
        rst = r;
        bus.slcg_en_src                   = s;
        bus.cfg_hold_cycles               = c;
        bus.dla_clk_ovr_on_sync           = o[0];
        bus.global_clk_ovr_on_sync        = o[1];
        bus.tmc2slcg_disable_clock_gating = o[2];
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        int   snap[4];

        // reset and idle
        add(1, 8'hFF, 8'd3, 3'b000, 4'hF, 4'h0, "reset0");
        add(1, 8'hFF, 8'd3, 3'b000, 4'hF, 4'h0, "reset1");
        add(0, 8'hFF, 8'd3, 3'b000, 4'hF, 4'h0, "run_idle");
        // ch0 hold 3
        add(0, 8'hFD, 8'd3, 3'b000, 4'hF, 4'h0, "ch0_drain1");
        add(0, 8'hFD, 8'd3, 3'b000, 4'hF, 4'h0, "ch0_drain2");
        add(0, 8'hFD, 8'd3, 3'b000, 4'hF, 4'h0, "ch0_drain3");
        add(0, 8'hFD, 8'd3, 3'b000, 4'hE, 4'h1, "ch0_gated");
        add(0, 8'hFD, 8'd3, 3'b000, 4'hE, 4'h1, "ch0_gated_hold");
        add(0, 8'hFF, 8'd3, 3'b000, 4'hF, 4'h0, "ch0_wake");
        // ch2 hold 0
        add(0, 8'hCF, 8'd0, 3'b000, 4'hB, 4'h4, "ch2_gate_now");
        add(0, 8'hCF, 8'd0, 3'b000, 4'hB, 4'h4, "ch2_gated_hold");
        add(0, 8'hFF, 8'd0, 3'b000, 4'hF, 4'h0, "ch2_wake");
        // ch3 hold 5, short gap then full drain
        add(0, 8'h3F, 8'd5, 3'b000, 4'hF, 4'h0, "ch3_gap1");
        add(0, 8'h3F, 8'd5, 3'b000, 4'hF, 4'h0, "ch3_gap2");
        add(0, 8'hFF, 8'd5, 3'b000, 4'hF, 4'h0, "ch3_back_run");
        for (int i = 0; i < 5; i++)
            add(0, 8'h3F, 8'd5, 3'b000, 4'hF, 4'h0, "ch3_drain5");
        add(0, 8'h3F, 8'd5, 3'b000, 4'h7, 4'h8, "ch3_gated");
        add(0, 8'hFF, 8'd5, 3'b000, 4'hF, 4'h0, "ch3_wake");
        // all gated, overrides
        add(0, 8'h00, 8'd0, 3'b000, 4'h0, 4'hF, "all_gated");
        add(0, 8'h00, 8'd0, 3'b100, 4'hF, 4'hF, "ovr_tmc");
        add(0, 8'h00, 8'd0, 3'b000, 4'h0, 4'hF, "ovr_off1");
        add(0, 8'h00, 8'd0, 3'b001, 4'hF, 4'hF, "ovr_dla");
        add(0, 8'h00, 8'd0, 3'b010, 4'hF, 4'hF, "ovr_global");
        add(0, 8'h00, 8'd0, 3'b000, 4'h0, 4'hF, "ovr_off2");
        add(0, 8'hFF, 8'd0, 3'b000, 4'hF, 4'h0, "all_wake");
        // simultaneous drain on all channels
        add(0, 8'h00, 8'd2, 3'b000, 4'hF, 4'h0, "all_drain1");
        add(0, 8'h00, 8'd2, 3'b000, 4'hF, 4'h0, "all_drain2");
        add(0, 8'h00, 8'd2, 3'b000, 4'h0, 4'hF, "all_gated2");
        add(0, 8'hFF, 8'd2, 3'b000, 4'hF, 4'h0, "all_wake2");
        // single source low is enough to drop the request
        add(0, 8'hFE, 8'd0, 3'b000, 4'hE, 4'h1, "ch0_one_src");
        add(0, 8'hFF, 8'd0, 3'b000, 4'hF, 4'h0, "ch0_one_src_wake");
        // reset mid-drain on ch1, then cfg change mid-drain
        add(0, 8'hF3, 8'd4, 3'b000, 4'hF, 4'h0, "ch1_drain_a");
        add(0, 8'hF3, 8'd4, 3'b000, 4'hF, 4'h0, "ch1_drain_b");
        add(1, 8'hF3, 8'd4, 3'b000, 4'hF, 4'h0, "ch1_reset_mid");
        add(0, 8'hF3, 8'd4, 3'b000, 4'hF, 4'h0, "ch1_reenter");
        add(0, 8'hF3, 8'd1, 3'b000, 4'hF, 4'h0, "ch1_cfgchg1");
        add(0, 8'hF3, 8'd1, 3'b000, 4'hF, 4'h0, "ch1_cfgchg2");
        add(0, 8'hF3, 8'd1, 3'b000, 4'hF, 4'h0, "ch1_cfgchg3");
        add(0, 8'hF3, 8'd1, 3'b000, 4'hD, 4'h2, "ch1_gated");
        add(0, 8'hFF, 8'd1, 3'b000, 4'hF, 4'h0, "ch1_wake");

        drive(1, 8'hFF, 8'd3, 3'b000);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].src, vecs[i].cfg, vecs[i].ovr);
            e.en = vecs[i].exp_en; e.g = vecs[i].exp_g; e.name = vecs[i].name;
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            check({e.name, "_en"}, 32'(bus.slcg_clk_en), 32'(e.en));
            check({e.name, "_gated"}, 32'(bus.slcg_ch_gated), 32'(e.g));
        end

        // gated clocks keep running while reset is held
        drive(1, 8'hFF, 8'd3, 3'b000);
        cycles(1);
        for (int i = 0; i < 4; i++) snap[i] = rise[i];
        cycles(4);
        for (int i = 0; i < 4; i++) check($sformatf("rst_clk_toggle%0d", i), 32'(rise[i] - snap[i]), 32'd4);

        // wake latency on ch2: no rise at the sampling edge, one at the next
        drive(0, 8'hCF, 8'd0, 3'b000);
        cycles(2);
        check("wake_pre_gated", 32'(bus.slcg_ch_gated), 32'h4);
        snap[2] = rise[2];
        bus.slcg_en_src = 8'hFF;
        @(posedge clk); #1;
        check("wake_no_rise_at_t", 32'(rise[2] - snap[2]), 32'd0);
        check("wake_en_after_t", 32'(bus.slcg_clk_en[2]), 32'd1);
        @(posedge clk); #1;
        check("wake_rise_at_t1", 32'(rise[2] - snap[2]), 32'd1);
        @(negedge clk);

        // override takes effect combinationally and stops the clock on release
        drive(0, 8'h00, 8'd0, 3'b000);
        cycles(1);
        check("ovr_pre_en", 32'(bus.slcg_clk_en), 32'h0);
        bus.tmc2slcg_disable_clock_gating = 1'b1;
        #1;
        check("ovr_same_cycle_en", 32'(bus.slcg_clk_en), 32'hF);
        check("ovr_same_cycle_gated", 32'(bus.slcg_ch_gated), 32'hF);
        @(negedge clk);
        snap[0] = rise[0];
        cycles(2);
        check("ovr_clk_runs", 32'(rise[0] - snap[0]), 32'd2);
        bus.tmc2slcg_disable_clock_gating = 1'b0;
        #1;
        check("ovr_release_en", 32'(bus.slcg_clk_en), 32'h0);
        for (int i = 0; i < 4; i++) snap[i] = rise[i];
        cycles(3);
        for (int i = 0; i < 4; i++) check($sformatf("ovr_release_stop%0d", i), 32'(rise[i] - snap[i]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
